// File: rtl/compression_gain_smoother_pkg.sv
// Shared constants, state encoding and dB-domain helpers for the compressor
// gain path (gain computer and gain smoother).
package compression_gain_smoother_pkg;

    localparam int FRAC_BITS = 4;
    localparam int DB_W      = 7;
    localparam int ENV_W     = DB_W + FRAC_BITS;
    localparam int GR_W      = 9;
    localparam int GAIN_W    = 8;
    localparam int SAMPLE_W  = 8;
    localparam int PROD_W    = 17;

    localparam logic [DB_W-1:0]        DB_MAX  = 7'd127;
    localparam logic signed [GR_W-1:0] GR_ZERO = 9'sd0;
    localparam logic signed [GR_W-1:0] GR_MAX  = 9'sd127;
    localparam logic [GAIN_W-1:0]      GAIN_UNITY = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SMOOTH  = 3'd1,
        ST_LOOKUP  = 3'd2,
        ST_ROMWAIT = 3'd3,
        ST_APPLY   = 3'd4
    } state_e;

    // Negative requests mean no attenuation; anything past DB_MAX saturates.
    function automatic logic [DB_W-1:0] clamp_db(input logic signed [GR_W-1:0] gr);
        logic [DB_W-1:0] r;
        if (gr < GR_ZERO) begin
            r = '0;
        end else if (gr > GR_MAX) begin
            r = DB_MAX;
        end else begin
            r = gr[DB_W-1:0];
        end
        return r;
    endfunction

    // One-pole step with a 1-LSB floor so the envelope always lands on target.
    function automatic logic [ENV_W-1:0] env_next(input logic [ENV_W-1:0] t,
                                                  input logic [ENV_W-1:0] e,
                                                  input int unsigned      atk_shift,
                                                  input int unsigned      rel_shift);
        logic [ENV_W-1:0] diff;
        logic [ENV_W-1:0] step;
        logic [ENV_W-1:0] r;
        if (t > e) begin
            diff = t - e;
            step = diff >> atk_shift;
            step = (step == '0) ? 11'd1 : step;
            r    = e + step;
        end else if (t < e) begin
            diff = e - t;
            step = diff >> rel_shift;
            step = (step == '0) ? 11'd1 : step;
            r    = e - step;
        end else begin
            r = e;
        end
        return r;
    endfunction

endpackage

// File: rtl/compression_gain_smoother_if.sv
// Handshake and data bundle between the gain computer / audio path and the
// gain smoother.
interface compression_gain_smoother_if;
    import compression_gain_smoother_pkg::*;

    logic                       start;
    logic                       bypass;
    logic signed [GR_W-1:0]     gain_reduction_db;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic [GAIN_W-1:0]          gain_linear;
    logic [DB_W-1:0]            smoothed_db;
    logic                       done;

    modport master (
        output start, bypass, gain_reduction_db, sample_in,
        input  sample_out, gain_linear, smoothed_db, done
    );

    modport slave (
        input  start, bypass, gain_reduction_db, sample_in,
        output sample_out, gain_linear, smoothed_db, done
    );

endinterface

// File: rtl/compression_gain_smoother_db_to_linear_rom.sv
// Attenuation (whole dB) to linear Q0.8 gain table, min(255, round(256*10^(-d/20))),
// with a registered read port.
module compression_gain_smoother_db_to_linear_rom
    import compression_gain_smoother_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [DB_W-1:0]   addr,
    output logic [GAIN_W-1:0] data
);

    logic [GAIN_W-1:0] data_q;

    function automatic logic [GAIN_W-1:0] rom_lookup(input logic [DB_W-1:0] a);
        logic [GAIN_W-1:0] g;
        case (a)
            7'd0:  g = 8'd255;  7'd1:  g = 8'd228;  7'd2:  g = 8'd203;  7'd3:  g = 8'd181;
            7'd4:  g = 8'd162;  7'd5:  g = 8'd144;  7'd6:  g = 8'd128;  7'd7:  g = 8'd114;
            7'd8:  g = 8'd102;  7'd9:  g = 8'd91;   7'd10: g = 8'd81;   7'd11: g = 8'd72;
            7'd12: g = 8'd64;   7'd13: g = 8'd57;   7'd14: g = 8'd51;   7'd15: g = 8'd46;
            7'd16: g = 8'd41;   7'd17: g = 8'd36;   7'd18: g = 8'd32;   7'd19: g = 8'd29;
            7'd20: g = 8'd26;   7'd21: g = 8'd23;   7'd22: g = 8'd20;   7'd23: g = 8'd18;
            7'd24: g = 8'd16;   7'd25: g = 8'd14;   7'd26: g = 8'd13;   7'd27: g = 8'd11;
            7'd28: g = 8'd10;   7'd29: g = 8'd9;    7'd30: g = 8'd8;    7'd31: g = 8'd7;
            7'd32: g = 8'd6;    7'd33: g = 8'd6;    7'd34: g = 8'd5;    7'd35: g = 8'd5;
            7'd36: g = 8'd4;    7'd37: g = 8'd4;    7'd38: g = 8'd3;    7'd39: g = 8'd3;
            7'd40: g = 8'd3;    7'd41: g = 8'd2;    7'd42: g = 8'd2;    7'd43: g = 8'd2;
            7'd44: g = 8'd2;    7'd45: g = 8'd1;    7'd46: g = 8'd1;    7'd47: g = 8'd1;
            7'd48: g = 8'd1;    7'd49: g = 8'd1;    7'd50: g = 8'd1;    7'd51: g = 8'd1;
            7'd52: g = 8'd1;    7'd53: g = 8'd1;    7'd54: g = 8'd1;
            default: g = 8'd0;
        endcase
        return g;
    endfunction

    // Synchronous read; output holds between enabled reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= rom_lookup(addr);
        end else begin
            data_q <= data_q;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/compression_gain_smoother.sv
// Smooths the requested gain reduction with attack/release ballistics in the dB
// domain, converts it to a linear gain and scales the accompanying sample.
module compression_gain_smoother
    import compression_gain_smoother_pkg::*;
#(
    parameter int unsigned ATTACK_SHIFT  = 1,
    parameter int unsigned RELEASE_SHIFT = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    compression_gain_smoother_if.slave   bus
);

    state_e                     state_q, state_d;
    logic signed [GR_W-1:0]     gr_q, gr_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       bypass_q, bypass_d;
    logic [ENV_W-1:0]           env_q, env_d;
    logic signed [SAMPLE_W-1:0] sample_out_q, sample_out_d;
    logic [GAIN_W-1:0]          gain_q, gain_d;
    logic [DB_W-1:0]            sdb_q, sdb_d;
    logic                       done_q, done_d;

    logic [GAIN_W-1:0]          rom_data_s;
    logic [GAIN_W-1:0]          g_s;
    logic signed [PROD_W-1:0]   sample_ext_s;
    logic signed [PROD_W-1:0]   gain_ext_s;
    logic signed [PROD_W-1:0]   prod_s;

    compression_gain_smoother_db_to_linear_rom u_rom (
        .clock (clock),
        .reset (reset),
        .en    (state_q == ST_LOOKUP),
        .addr  (env_q[ENV_W-1:FRAC_BITS]),
        .data  (rom_data_s)
    );

    // Gain selection and signed scaling; the product always fits, |out| <= |in|.
    always_comb begin
        if (bypass_q) begin
            g_s = GAIN_UNITY;
        end else begin
            g_s = rom_data_s;
        end
        sample_ext_s = {{(PROD_W-SAMPLE_W){sample_q[SAMPLE_W-1]}}, sample_q};
        gain_ext_s   = {{(PROD_W-GAIN_W){1'b0}}, g_s};
        prod_s       = sample_ext_s * gain_ext_s;
    end

    // Next-state and datapath updates for the smoothing sequence.
    always_comb begin
        state_d      = state_q;
        gr_d         = gr_q;
        sample_d     = sample_q;
        bypass_d     = bypass_q;
        env_d        = env_q;
        sample_out_d = sample_out_q;
        gain_d       = gain_q;
        sdb_d        = sdb_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    gr_d     = bus.gain_reduction_db;
                    sample_d = bus.sample_in;
                    bypass_d = bus.bypass;
                    state_d  = ST_SMOOTH;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SMOOTH: begin
                env_d   = env_next({clamp_db(gr_q), {FRAC_BITS{1'b0}}}, env_q,
                                   ATTACK_SHIFT, RELEASE_SHIFT);
                state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                state_d = ST_ROMWAIT;
            end
            ST_ROMWAIT: begin
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                sample_out_d = SAMPLE_W'(prod_s >>> 5'd8);
                gain_d       = g_s;
                sdb_d        = env_q[ENV_W-1:FRAC_BITS];
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            gr_q         <= '0;
            sample_q     <= '0;
            bypass_q     <= 1'b0;
            env_q        <= '0;
            sample_out_q <= '0;
            gain_q       <= '0;
            sdb_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gr_q         <= gr_d;
            sample_q     <= sample_d;
            bypass_q     <= bypass_d;
            env_q        <= env_d;
            sample_out_q <= sample_out_d;
            gain_q       <= gain_d;
            sdb_q        <= sdb_d;
            done_q       <= done_d;
        end
    end

    assign bus.sample_out  = sample_out_q;
    assign bus.gain_linear = gain_q;
    assign bus.smoothed_db = sdb_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_compression_gain_smoother.sv
// Directed bench for compression_gain_smoother: scoreboard of expected outputs
// built from an independent envelope/ROM model, checked on each done pulse.
module tb_compression_gain_smoother;

    logic clk;
    logic rst_n;

    compression_gain_smoother_if bus ();

    compression_gain_smoother dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int so;
        int g;
        int db;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   env_m        = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rom_m(input int d);
        real v;
        int  r;
        v = 256.0 * $pow(10.0, -d / 20.0);
        r = $rtoi(v + 0.5);
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic int env_step(input int t, input int e);
        int st;
        if (t > e) begin
            st = (t - e) >> 1;
            if (st < 1) st = 1;
            return e + st;
        end else if (t < e) begin
            st = (e - t) >> 4;
            if (st < 1) st = 1;
            return e - st;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Pulse start for one cycle and push the model's expectation.
    task automatic pulse_start(input int gr, input int s, input bit byp);
        exp_t e;
        int   t;
        int   g;
        t = (gr < 0) ? 0 : ((gr > 127) ? 127 : gr);
        env_m = env_step(t * 16, env_m);
        g = byp ? 255 : rom_m(env_m >> 4);
        e.so = (s * g) >>> 8;
        e.g  = g;
        e.db = env_m >> 4;
        sb_q.push_back(e);
        bus.gain_reduction_db = 9'(gr);
        bus.sample_in         = 8'(s);
        bus.bypass            = byp;
        bus.start             = 1'b1;
        tick();
        bus.start             = 1'b0;
    endtask

    task automatic pulse_ignored(input int gr, input int s, input bit byp);
        bus.gain_reduction_db = 9'(gr);
        bus.sample_in         = 8'(s);
        bus.bypass            = byp;
        bus.start             = 1'b1;
        tick();
        bus.start             = 1'b0;
    endtask

    // Wait for done (edges counted from the start edge), then check against the scoreboard.
    task automatic wait_done(input string tag, input int elapsed);
        int   lat;
        exp_t e;
        lat = -1;
        for (int n = elapsed + 1; n <= 12; n++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (lat > 0) begin
                chk({tag, "_sample_out"}, int'($signed(bus.sample_out)), e.so);
                chk({tag, "_gain"}, int'(bus.gain_linear), e.g);
                chk({tag, "_smoothed_db"}, int'(bus.smoothed_db), e.db);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        env_m = 0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int extra;
        rst_n                 = 1'b0;
        bus.start             = 1'b0;
        bus.bypass            = 1'b0;
        bus.gain_reduction_db = '0;
        bus.sample_in         = '0;
        tick();
        tick();
        chk("rst_sample_out", int'($signed(bus.sample_out)), 0);
        chk("rst_gain", int'(bus.gain_linear), 0);
        chk("rst_db", int'(bus.smoothed_db), 0);
        chk("rst_done", int'(bus.done), 0);
        rst_n = 1'b1;
        tick();

        // Unity gain from a zero envelope.
        pulse_start(0, 100, 1'b0);
        wait_done("unity", 0);
        chk("unity_gain_const", int'(bus.gain_linear), 255);
        chk("unity_out_const", int'($signed(bus.sample_out)), 99);
        chk("unity_db_const", int'(bus.smoothed_db), 0);

        // Attack towards 24 dB.
        pulse_start(24, 100, 1'b0);
        wait_done("atk1", 0);
        chk("atk1_db_const", int'(bus.smoothed_db), 12);
        chk("atk1_gain_const", int'(bus.gain_linear), 64);
        chk("atk1_out_const", int'($signed(bus.sample_out)), 25);
        pulse_start(24, -40, 1'b0);
        wait_done("atk2", 0);
        chk("atk2_db_const", int'(bus.smoothed_db), 18);
        pulse_start(24, 7, 1'b0);
        wait_done("atk3", 0);
        chk("atk3_db_const", int'(bus.smoothed_db), 21);

        // Reset in the middle of APPLY.
        pulse_start(24, 50, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_sample_out", int'($signed(bus.sample_out)), 0);
        chk("midrst_gain", int'(bus.gain_linear), 0);
        chk("midrst_db", int'(bus.smoothed_db), 0);
        chk("midrst_done", int'(bus.done), 0);
        void'(sb_q.pop_front());
        env_m = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_done", int'(bus.done), 0);
        end
        rst_n = 1'b1;
        tick();
        pulse_start(24, 100, 1'b0);
        wait_done("postrst", 0);
        chk("postrst_db_const", int'(bus.smoothed_db), 12);

        // Converge to 24 dB, then release.
        for (int i = 0; i < 20 && env_m != 384; i++) begin
            pulse_start(24, 3 * i - 20, 1'b0);
            wait_done("conv", 0);
        end
        pulse_start(0, 100, 1'b0);
        wait_done("rel", 0);
        chk("rel_db_const", int'(bus.smoothed_db), 22);

        // Minimum release step down to zero.
        do_reset();
        for (int i = 0; i < 10 && env_m != 16; i++) begin
            pulse_start(1, 60, 1'b0);
            wait_done("to1db", 0);
        end
        pulse_start(0, 60, 1'b0);
        wait_done("minstep", 0);
        chk("minstep_db_const", int'(bus.smoothed_db), 0);
        for (int i = 0; i < 20 && env_m != 0; i++) begin
            pulse_start(0, -60, 1'b0);
            wait_done("tozero", 0);
        end

        // Clamping and bypass.
        pulse_start(-5, 100, 1'b0);
        wait_done("clamp_neg", 0);
        chk("clamp_neg_gain_const", int'(bus.gain_linear), 255);
        pulse_start(200, 100, 1'b0);
        wait_done("clamp_hi", 0);
        chk("clamp_hi_db_const", int'(bus.smoothed_db), 63);
        pulse_start(0, -128, 1'b1);
        wait_done("bypass", 0);
        chk("bypass_out_const", int'($signed(bus.sample_out)), -128);
        chk("bypass_gain_const", int'(bus.gain_linear), 255);
        chk("bypass_db_const", int'(bus.smoothed_db), 59);

        // Handshake: busy start ignored; start on done cycle accepted.
        do_reset();
        pulse_start(6, 100, 1'b0);
        tick();
        tick();
        pulse_ignored(127, -100, 1'b1);
        wait_done("busy", 3);
        pulse_start(6, -100, 1'b0);
        chk("done_width", int'(bus.done), 0);
        wait_done("ondone", 0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1) extra++;
        end
        chk("no_extra_done", extra, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
